// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI-NOR responder for READ (0x03), JEDEC ID (0x9F) and STATUS (0x05), oversampled on clk.
// Define SPI_RESP_QUAD_EN to add the 0x6B quad output read with its DUMMY phase.
module spi_flash_responder #(
   parameter int ADDR_WIDTH = 24,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs_n,
   input  logic [3:0] qdi,
   output logic [3:0] qdo,
   output logic [3:0] oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic mem_rd,
   input  logic [7:0] mem_data
);
`ifdef SPI_RESP_QUAD_EN
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE} state_t;
`else
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
`endif
   state_t state, state_n;
   logic [1:0] sclk_q, cs_q, vld, idx;
   logic [3:0] qdi_q1, qdi_q2;
   logic sclk_d, armed, cs_s, din, rise, fall, quad, quad_cmd, out_st, last, rd_d, unused_qdi;
   logic [4:0] bit_cnt;
   logic [2:0] pos;
   logic [6:0] sh;
   logic [7:0] tx, pf, rx_cmd, next_byte;
   logic [22:0] addr;
   logic [23:0] addr_full;
   // vld masks the reset value of the cs_n synchronizer so a select held through reset is never taken
   always_ff @(posedge clk)
      if (rst) begin
         sclk_q <= 2'b00;
         cs_q <= 2'b11;
         qdi_q1 <= 4'h0;
         qdi_q2 <= 4'h0;
         sclk_d <= 1'b0;
         vld <= 2'b00;
         armed <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[0], sclk};
         cs_q <= {cs_q[0], cs_n};
         qdi_q1 <= qdi;
         qdi_q2 <= qdi_q1;
         sclk_d <= sclk_q[1];
         vld <= {vld[0], 1'b1};
         armed <= armed | (vld[1] & cs_q[1]);
      end
   assign cs_s = cs_q[1];
   assign din = qdi_q2[0];
   assign unused_qdi = ^qdi_q2[3:1];
   assign rise = sclk_q[1] & ~sclk_d & ~cs_s;
   assign fall = ~sclk_q[1] & sclk_d & ~cs_s;
   assign rx_cmd = {sh, din};
   assign addr_full = {addr, din};
   assign out_st = state == DATA || state == ID || state == STAT;
   assign last = quad ? pos[0] : pos == 3'd7;
   assign oe = !out_st ? 4'h0 : quad ? 4'hF : 4'b0010;
   assign qdo = !out_st ? 4'h0 : quad ? tx[7:4] : {2'b00, tx[7], 1'b0};
   assign next_byte = state == DATA ? pf : state == STAT ? 8'h00 : idx == 2'd0 ? JEDEC_ID[23:16] :
                      idx == 2'd1 ? JEDEC_ID[15:8] : idx == 2'd2 ? JEDEC_ID[7:0] : 8'hFF;
`ifdef SPI_RESP_QUAD_EN
   assign quad_cmd = rx_cmd == 8'h6B;
`else
   assign quad_cmd = 1'b0;
   assign quad = 1'b0;
`endif
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state;
      if (cs_s) state_n = IDLE;
      else
         case (state)
            IDLE: state_n = armed ? CMD : IDLE;
            CMD: if (rise && bit_cnt == 5'd7)
               state_n = (rx_cmd == 8'h03 || quad_cmd) ? ADDR : rx_cmd == 8'h9F ? ID : rx_cmd == 8'h05 ? STAT : IGNORE;
`ifdef SPI_RESP_QUAD_EN
            ADDR: if (rise && bit_cnt == 5'd23) state_n = quad ? DUMMY : DATA;
            DUMMY: if (rise && bit_cnt == 5'd7) state_n = DATA;
`else
            ADDR: if (rise && bit_cnt == 5'd23) state_n = DATA;
`endif
            default: ;
         endcase
   end
   // pos starts at 7 so the first falling edge of an output phase loads a fresh byte
   always_ff @(posedge clk)
      if (rst) begin
         bit_cnt <= '0;
         sh <= '0;
         addr <= '0;
         tx <= '0;
         pf <= '0;
         pos <= 3'd7;
         idx <= '0;
         mem_addr <= '0;
         mem_rd <= 1'b0;
         rd_d <= 1'b0;
`ifdef SPI_RESP_QUAD_EN
         quad <= 1'b0;
`endif
      end else begin
         mem_rd <= 1'b0;
         rd_d <= mem_rd;
         if (rd_d) pf <= mem_data;
         if (state == IDLE) begin
            bit_cnt <= '0;
            sh <= '0;
            tx <= '0;
            pos <= 3'd7;
            idx <= '0;
`ifdef SPI_RESP_QUAD_EN
            quad <= 1'b0;
`endif
         end else if (rise && !out_st && state != IGNORE) begin
            bit_cnt <= state_n != state ? 5'd0 : bit_cnt + 5'd1;
            sh <= rx_cmd[6:0];
            addr <= addr_full[22:0];
`ifdef SPI_RESP_QUAD_EN
            if (state == CMD) quad <= quad_cmd;
`endif
            if (state == ADDR && state_n != ADDR) begin
               mem_rd <= 1'b1;
               mem_addr <= addr_full[ADDR_WIDTH-1:0];
            end
         end else if (fall && out_st) begin
            tx <= last ? next_byte : quad ? {tx[3:0], 4'h0} : {tx[6:0], 1'b0};
            pos <= last ? 3'd0 : pos + 3'd1;
            idx <= (last && idx != 2'd3) ? idx + 2'd1 : idx;
            // single mode fetches while bit 0 goes out, quad while the high nibble goes out
            if (state == DATA && (quad ? last : pos == 3'd6)) begin
               mem_rd <= 1'b1;
               mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
         end
      end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: SPI master with a byte scoreboard, vector table plus hand-built abort/reset/glitch sequences.
module tb_spi_flash_responder;
   localparam int H = 5;
   logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1;
   logic [3:0] qdi = 4'h0, qdo, oe;
   logic [23:0] mem_addr;
   logic mem_rd;
   logic [7:0] mem_data = 8'h00;
   int checks = 0, errors = 0, rd_cnt = 0;
   logic [7:0] exp_q[$];
   typedef struct packed {
      logic [3:0] n, hdr;
      logic [63:0] tx, rx;
      logic [3:0] oe, rd_min, rd_max;
   } vec_t;
   vec_t vt [6];

   spi_flash_responder dut (.clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .qdi(qdi), .qdo(qdo), .oe(oe),
                            .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data));

   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem_addr[7:0];
      rd_cnt <= rd_cnt + (mem_rd ? 1 : 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] b, input int nb, output logic [7:0] r, output logic [3:0] oe_or, output logic [3:0] oe_and);
      r = 8'h00;
      oe_or = 4'h0;
      oe_and = 4'hF;
      for (int i = 7; i > 7 - nb; i--) begin
         qdi[0] = b[i];
         repeat (H) @(negedge clk);
         sclk = 1'b1;
         r[i] = qdo[1];
         oe_or = oe_or | oe;
         oe_and = oe_and & oe;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic xbyte(input logic [7:0] b, input logic [7:0] exp, input logic [3:0] exp_oe, input bit chk, input string name);
      logic [7:0] r;
      logic [3:0] oo, oa;
      if (chk) exp_q.push_back(exp);
      xfer(b, 8, r, oo, oa);
      check({name, " oe"}, {oo, oa}, {exp_oe, exp_oe});
      if (chk) check({name, " data"}, r, exp_q.pop_front());
   endtask

   task automatic sel();
      repeat (H) @(negedge clk);
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic desel();
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   initial begin
      int nv, rd0;
      logic [7:0] r, b, exp_b;
      logic [3:0] oo, oa, q, o;
      logic [15:0] nibs;
      vt[0] = {4'd5, 4'd1, 64'h9F00000000000000, 64'hEF4016FF00000000, 4'h2, 4'd0, 4'd0};
      vt[1] = {4'd7, 4'd4, 64'h0300001000000000, 64'h1011120000000000, 4'h2, 4'd3, 4'd4};
      vt[2] = {4'd6, 4'd4, 64'h03FFFFFF00000000, 64'hFF00000000000000, 4'h2, 4'd2, 4'd3};
      vt[3] = {4'd3, 4'd1, 64'h0500000000000000, 64'h0000000000000000, 4'h2, 4'd0, 4'd0};
      vt[4] = {4'd5, 4'd1, 64'h0211223344000000, 64'h0000000000000000, 4'h0, 4'd0, 4'd0};
      vt[5] = {4'd6, 4'd1, 64'h6B00002000000000, 64'h0000000000000000, 4'h0, 4'd0, 4'd0};
`ifdef SPI_RESP_QUAD_EN
      nv = 5;
`else
      nv = 6;
`endif
      repeat (4) @(negedge clk);
      check("reset oe", oe, 0);
      check("reset qdo", qdo, 0);
      check("reset mem_rd", mem_rd, 0);
      check("reset mem_addr", mem_addr, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int v = 0; v < nv; v++) begin
         rd0 = rd_cnt;
         sel();
         for (int i = 0; i < int'(vt[v].n); i++) begin
            b = vt[v].tx[63 - 8 * i -: 8];
            if (i >= int'(vt[v].hdr)) exp_q.push_back(vt[v].rx[63 - 8 * (i - int'(vt[v].hdr)) -: 8]);
            xfer(b, 8, r, oo, oa);
            if (i < int'(vt[v].hdr)) check($sformatf("vec%0d hdr%0d oe", v, i), {oo, oa}, 8'h00);
            else begin
               check($sformatf("vec%0d byte%0d oe", v, i), {oo, oa}, {vt[v].oe, vt[v].oe});
               exp_b = exp_q.pop_front();
               if (vt[v].oe != 4'h0) check($sformatf("vec%0d byte%0d data", v, i), r, exp_b);
            end
         end
         desel();
         checks++;
         if (rd_cnt - rd0 < int'(vt[v].rd_min) || rd_cnt - rd0 > int'(vt[v].rd_max)) begin
            errors++;
            $display("FAIL vec%0d mem_rd count: got %0d expected %0d..%0d", v, rd_cnt - rd0, vt[v].rd_min, vt[v].rd_max);
         end
      end
      sel();
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "idabort cmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "idabort byte0");
      check("idabort oe before", oe, 4'h2);
      cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("idabort oe 3clk", oe, 4'h0);
      repeat (2 * H) @(negedge clk);
      sel();
      xfer(8'h05, 4, r, oo, oa);
      desel();
      sel();
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "partial next cmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "partial next byte0");
      desel();
      rd0 = rd_cnt;
      sel();
      xbyte(8'h03, 8'h00, 4'h0, 1'b0, "addrabort cmd");
      xbyte(8'h00, 8'h00, 4'h0, 1'b0, "addrabort a2");
      cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("addrabort oe 3clk", oe, 4'h0);
      repeat (2 * H) @(negedge clk);
      check("addrabort mem_rd count", rd_cnt - rd0, 0);
      sel();
      xbyte(8'h05, 8'h00, 4'h0, 1'b0, "stat after abort cmd");
      xbyte(8'h00, 8'h00, 4'h2, 1'b1, "stat after abort");
      desel();
      sel();
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "glitch cmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "glitch byte0");
      cs_n = 1'b1;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "glitch recmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "glitch rebyte0");
      desel();
      sel();
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "midrst cmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "midrst byte0");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst oe", oe, 4'h0);
      rst = 1'b0;
      repeat (H) @(negedge clk);
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "held select cmd");
      xbyte(8'h00, 8'h00, 4'h0, 1'b0, "held select byte");
      desel();
      sel();
      xbyte(8'h9F, 8'h00, 4'h0, 1'b0, "reselect cmd");
      xbyte(8'h00, 8'hEF, 4'h2, 1'b1, "reselect byte0");
      desel();
`ifdef SPI_RESP_QUAD_EN
      sel();
      xbyte(8'h6B, 8'h00, 4'h0, 1'b0, "quad cmd");
      xbyte(8'h00, 8'h00, 4'h0, 1'b0, "quad a2");
      xbyte(8'h00, 8'h00, 4'h0, 1'b0, "quad a1");
      xbyte(8'h20, 8'h00, 4'h0, 1'b0, "quad a0");
      xbyte(8'h00, 8'h00, 4'h0, 1'b0, "quad dummy");
      nibs = 16'h2021;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({4'h0, nibs[15 - 4 * k -: 4]});
         repeat (H) @(negedge clk);
         sclk = 1'b1;
         q = qdo;
         o = oe;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
         check($sformatf("quad nib%0d", k), q, exp_q.pop_front());
         check($sformatf("quad nib%0d oe", k), o, 4'hF);
      end
      desel();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
